// File: rtl/apmu_cnt_pkg.sv
// Shared definitions for the event counter bank.
// Holds the parameter-range limits, the per-channel configuration struct,
// and a helper that sizes index ports so that a single-entry dimension
// still gets a 1-bit port.
package apmu_cnt_pkg;

    localparam int MaxCounters     = 16;
    localparam int MaxCounterWidth = 64;
    localparam int MaxEvents       = 32;

    // Wide enough for any event index below MaxEvents.
    localparam int CfgSelW = 5;

    typedef struct packed {
        logic [CfgSelW-1:0] sel;
        logic               en;
        logic               ie;
    } chan_cfg_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apmu_counter_channel.sv
// One counter channel: config register, live counter, shadow copy and
// sticky overflow flag.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   events_i             event pulse vector shared by all channels
//   cfg_we_i, cfg_i      config write strobe (already decoded) and data
//   cnt_we_i, cnth_we_i  low/high 32-bit value write strobes (decoded)
//   wr_val_i             value write data
//   ovf_clr_i            clear this channel's overflow flag
//   snap_i               copy live value into shadow
//   live_o, shadow_o     zero-extended 64-bit live and shadow values
//   ovf_o, ie_o          overflow flag and interrupt enable
module apmu_counter_channel
    import apmu_cnt_pkg::*;
#(
    parameter int CounterWidth = 48,
    parameter int NumEvents    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumEvents-1:0] events_i,
    input  logic                 cfg_we_i,
    input  chan_cfg_t            cfg_i,
    input  logic                 cnt_we_i,
    input  logic                 cnth_we_i,
    input  logic [31:0]          wr_val_i,
    input  logic                 ovf_clr_i,
    input  logic                 snap_i,
    output logic [63:0]          live_o,
    output logic [63:0]          shadow_o,
    output logic                 ovf_o,
    output logic                 ie_o
);

    chan_cfg_t               cfg_q;
    logic [CounterWidth-1:0] cnt_q, cnt_d, shadow_q;
    logic                    ovf_q, ovf_set;
    logic [MaxEvents-1:0]    ev_ext;
    logic                    hit;

    // Event indices at or beyond NumEvents never count.
    always_comb begin
        ev_ext = MaxEvents'(events_i);
        hit    = cfg_q.en && (int'(cfg_q.sel) < NumEvents) && ev_ext[cfg_q.sel];
    end

    // Priority: high-half write, then low-half write, then increment.
    // A write in the same cycle as an event swallows the increment.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (cnt_we_i || cnth_we_i) begin
            for (int b = 0; b < CounterWidth; b++) begin
                if (b >= 32) begin
                    if (cnth_we_i) cnt_d[b] = wr_val_i[5'(b % 32)];
                end else if (!cnth_we_i) begin
                    cnt_d[b] = wr_val_i[5'(b % 32)];
                end
            end
        end else if (hit) begin
            cnt_d   = cnt_q + CounterWidth'(1);
            ovf_set = &cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (snap_i)   shadow_q <= cnt_q;
            if (cfg_we_i) cfg_q    <= cfg_i;
            // A new overflow outranks a same-cycle clear.
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr_i);
        end
    end

    assign live_o   = 64'(cnt_q);
    assign shadow_o = 64'(shadow_q);
    assign ovf_o    = ovf_q;
    assign ie_o     = cfg_q.ie;

endmodule

// File: rtl/apmu_event_counter_bank.sv
// Bank of NumCounters event counters with per-channel event select,
// snapshot shadow bank, sticky overflow flags and a registered read port.
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   events_i                  per-cycle event pulses
//   cfg_we_i/sel/en/ie        channel config write (channel wr_idx_i)
//   wr_idx_i                  channel addressed by config/value writes
//   cnt_we_i, cnth_we_i       write low/high 32 bits with wr_val_i
//   ovf_clr_i                 W1C overflow flags
//   snap_i                    copy all live counters into shadows
//   rd_req_i/idx/shadow       read request; data one cycle later
//   rd_valid_o, rd_data_o     read response (data held when not valid)
//   ovf_o, irq_o              overflow flags, OR of ovf & ie
module apmu_event_counter_bank
    import apmu_cnt_pkg::*;
#(
    parameter int NumCounters  = 8,
    parameter int CounterWidth = 48,
    parameter int NumEvents    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumEvents-1:0]              events_i,
    input  logic                              cfg_we_i,
    input  logic [idx_width(NumEvents)-1:0]   cfg_sel_i,
    input  logic                              cfg_en_i,
    input  logic                              cfg_ie_i,
    input  logic [idx_width(NumCounters)-1:0] wr_idx_i,
    input  logic                              cnt_we_i,
    input  logic                              cnth_we_i,
    input  logic [31:0]                       wr_val_i,
    input  logic [NumCounters-1:0]            ovf_clr_i,
    input  logic                              snap_i,
    input  logic                              rd_req_i,
    input  logic [idx_width(NumCounters)-1:0] rd_idx_i,
    input  logic                              rd_shadow_i,
    output logic                              rd_valid_o,
    output logic [63:0]                       rd_data_o,
    output logic [NumCounters-1:0]            ovf_o,
    output logic                              irq_o
);

    if (NumCounters < 1 || NumCounters > MaxCounters) begin : g_bad_nc
        $error("NumCounters out of range 1..16");
    end
    if (CounterWidth < 1 || CounterWidth > MaxCounterWidth) begin : g_bad_cw
        $error("CounterWidth out of range 1..64");
    end
    if (NumEvents < 1 || NumEvents > MaxEvents) begin : g_bad_ne
        $error("NumEvents out of range 1..32");
    end

    logic [NumCounters-1:0][63:0] live_all, shadow_all;
    logic [NumCounters-1:0]       ovf_all, ie_all;
    chan_cfg_t                    cfg_wr;
    logic [63:0]                  rd_mux;
    logic                         rd_valid_q;
    logic [63:0]                  rd_data_q;

    assign cfg_wr = '{sel: CfgSelW'(cfg_sel_i), en: cfg_en_i, ie: cfg_ie_i};

    for (genvar i = 0; i < NumCounters; i++) begin : g_chan
        // Out-of-range wr_idx_i matches no channel, so the write is dropped.
        logic sel_me;
        assign sel_me = (int'(wr_idx_i) == i);

        apmu_counter_channel #(
            .CounterWidth (CounterWidth),
            .NumEvents    (NumEvents)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .events_i  (events_i),
            .cfg_we_i  (cfg_we_i & sel_me),
            .cfg_i     (cfg_wr),
            .cnt_we_i  (cnt_we_i & sel_me),
            .cnth_we_i (cnth_we_i & sel_me),
            .wr_val_i  (wr_val_i),
            .ovf_clr_i (ovf_clr_i[i]),
            .snap_i    (snap_i),
            .live_o    (live_all[i]),
            .shadow_o  (shadow_all[i]),
            .ovf_o     (ovf_all[i]),
            .ie_o      (ie_all[i])
        );
    end

    // Out-of-range rd_idx_i falls through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (int'(rd_idx_i) == i) rd_mux = rd_shadow_i ? shadow_all[i] : live_all[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) rd_data_q <= rd_mux;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign ovf_o      = ovf_all;
    assign irq_o      = |(ovf_all & ie_all);

endmodule

// File: tb/tb_apmu_event_counter_bank.sv
// Directed bench: two banks share every input; one is 48 bits wide, the
// other 8 bits wide so wrap/overflow is reachable with a single event.
// Six channels and twelve events leave room for out-of-range indices.
module tb_apmu_event_counter_bank;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [11:0] events_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_sel_i;
    logic        cfg_en_i, cfg_ie_i;
    logic [2:0]  wr_idx_i;
    logic        cnt_we_i, cnth_we_i;
    logic [31:0] wr_val_i;
    logic [5:0]  ovf_clr_i;
    logic        snap_i, rd_req_i, rd_shadow_i;
    logic [2:0]  rd_idx_i;

    logic        rd_valid_a, rd_valid_b, irq_a, irq_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [5:0]  ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    apmu_event_counter_bank #(.NumCounters(6), .CounterWidth(48), .NumEvents(12)) u_dut_w48 (
        .clk_i(clk_i), .rst_ni(rst_ni), .events_i(events_i), .cfg_we_i(cfg_we_i),
        .cfg_sel_i(cfg_sel_i), .cfg_en_i(cfg_en_i), .cfg_ie_i(cfg_ie_i), .wr_idx_i(wr_idx_i),
        .cnt_we_i(cnt_we_i), .cnth_we_i(cnth_we_i), .wr_val_i(wr_val_i), .ovf_clr_i(ovf_clr_i),
        .snap_i(snap_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_shadow_i(rd_shadow_i),
        .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a), .ovf_o(ovf_a), .irq_o(irq_a)
    );

    apmu_event_counter_bank #(.NumCounters(6), .CounterWidth(8), .NumEvents(12)) u_dut_w8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .events_i(events_i), .cfg_we_i(cfg_we_i),
        .cfg_sel_i(cfg_sel_i), .cfg_en_i(cfg_en_i), .cfg_ie_i(cfg_ie_i), .wr_idx_i(wr_idx_i),
        .cnt_we_i(cnt_we_i), .cnth_we_i(cnth_we_i), .wr_val_i(wr_val_i), .ovf_clr_i(ovf_clr_i),
        .snap_i(snap_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_shadow_i(rd_shadow_i),
        .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b), .ovf_o(ovf_b), .irq_o(irq_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input int idx, input int sel, input bit en, input bit ie);
        cfg_we_i = 1'b1; wr_idx_i = 3'(idx); cfg_sel_i = 4'(sel);
        cfg_en_i = en;   cfg_ie_i = ie;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic wr_lo(input int idx, input logic [31:0] val);
        cnt_we_i = 1'b1; wr_idx_i = 3'(idx); wr_val_i = val;
        tick();
        cnt_we_i = 1'b0;
    endtask

    task automatic wr_hi(input int idx, input logic [31:0] val);
        cnth_we_i = 1'b1; wr_idx_i = 3'(idx); wr_val_i = val;
        tick();
        cnth_we_i = 1'b0;
    endtask

    task automatic pulse(input logic [11:0] ev, input int n);
        events_i = ev;
        repeat (n) tick();
        events_i = '0;
    endtask

    // Issue a read, check valid plus both banks' data on the next cycle.
    task automatic read_chk(input string tag, input int idx, input bit sh,
                            input logic [63:0] exp_a, input logic [63:0] exp_b);
        rd_req_i = 1'b1; rd_idx_i = 3'(idx); rd_shadow_i = sh;
        tick();
        rd_req_i = 1'b0;
        chk({tag, ".vld"}, 64'(rd_valid_a), 64'd1);
        chk({tag, ".w48"}, rd_data_a, exp_a);
        chk({tag, ".w8"},  rd_data_b, exp_b);
    endtask

    initial begin
        rst_ni = 1'b0; events_i = '0; cfg_we_i = 1'b0; cfg_sel_i = '0;
        cfg_en_i = 1'b0; cfg_ie_i = 1'b0; wr_idx_i = '0; cnt_we_i = 1'b0;
        cnth_we_i = 1'b0; wr_val_i = '0; ovf_clr_i = '0; snap_i = 1'b0;
        rd_req_i = 1'b0; rd_idx_i = '0; rd_shadow_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst.vld",  64'(rd_valid_a), 64'd0);
        chk("rst.data", rd_data_a, 64'd0);
        chk("rst.ovf",  64'(ovf_a | ovf_b), 64'd0);
        chk("rst.irq",  64'(irq_a | irq_b), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Basic count: ch0 on event 3, five pulses
        cfg(0, 3, 1'b1, 1'b0);
        pulse(12'h008, 5);
        read_chk("cnt.ch0", 0, 1'b0, 64'd5, 64'd5);
        read_chk("cnt.ch1", 1, 1'b0, 64'd0, 64'd0);
        read_chk("cnt.ch5", 5, 1'b0, 64'd0, 64'd0);

        // Overflow on the 8-bit bank with ie=1
        cfg(1, 2, 1'b1, 1'b1);
        wr_lo(1, 32'hFF);
        pulse(12'h004, 1);
        chk("ovf.b",    64'(ovf_b), 64'h2);
        chk("ovf.irqb", 64'(irq_b), 64'd1);
        chk("ovf.a",    64'(ovf_a), 64'd0);
        chk("ovf.irqa", 64'(irq_a), 64'd0);
        read_chk("ovf.ch1", 1, 1'b0, 64'h100, 64'h0);
        ovf_clr_i = 6'h02; tick(); ovf_clr_i = '0;
        chk("clr.ovf", 64'(ovf_b), 64'd0);
        chk("clr.irq", 64'(irq_b), 64'd0);

        // Overflow with ie=0: flag sets, no interrupt
        cfg(1, 2, 1'b1, 1'b0);
        wr_lo(1, 32'hFF);
        pulse(12'h004, 1);
        chk("noie.ovf", 64'(ovf_b), 64'h2);
        chk("noie.irq", 64'(irq_b), 64'd0);
        ovf_clr_i = 6'h02; tick(); ovf_clr_i = '0;
        chk("noie.clr", 64'(ovf_b), 64'd0);

        // Set and clear in the same cycle: set wins
        wr_lo(1, 32'hFF);
        events_i = 12'h004; ovf_clr_i = 6'h02;
        tick();
        events_i = '0; ovf_clr_i = '0;
        chk("setclr.ovf", 64'(ovf_b), 64'h2);
        ovf_clr_i = 6'h02; tick(); ovf_clr_i = '0;
        chk("setclr.clr", 64'(ovf_b), 64'd0);

        // Snapshot with coincident event on ch2
        cfg(2, 4, 1'b1, 1'b0);
        wr_lo(2, 32'h10);
        snap_i = 1'b1; events_i = 12'h010;
        tick();
        snap_i = 1'b0; events_i = '0;
        read_chk("snap.sh2",   2, 1'b1, 64'h10, 64'h10);
        read_chk("snap.live2", 2, 1'b0, 64'h11, 64'h11);
        read_chk("snap.sh0",   0, 1'b1, 64'd5,  64'd5);
        read_chk("snap.sh1",   1, 1'b1, 64'h100, 64'h0);

        // Shadow read alongside a new snapshot returns the old shadow
        snap_i = 1'b1; rd_req_i = 1'b1; rd_idx_i = 3'd2; rd_shadow_i = 1'b1;
        tick();
        snap_i = 1'b0; rd_req_i = 1'b0;
        chk("snaprd.vld", 64'(rd_valid_a), 64'd1);
        chk("snaprd.w48", rd_data_a, 64'h10);
        chk("snaprd.w8",  rd_data_b, 64'h10);
        read_chk("snaprd.new", 2, 1'b1, 64'h11, 64'h11);

        // Write beats coincident increment; high-half write; both strobes
        cfg(3, 5, 1'b1, 1'b0);
        cnt_we_i = 1'b1; wr_idx_i = 3'd3; wr_val_i = 32'h1234; events_i = 12'h020;
        tick();
        cnt_we_i = 1'b0; events_i = '0;
        read_chk("wr.lo", 3, 1'b0, 64'h1234, 64'h34);
        chk("wr.lo.noovf", 64'(ovf_a | ovf_b), 64'd0);
        wr_hi(3, 32'hA);
        read_chk("wr.hi", 3, 1'b0, 64'h0000_000A_0000_1234, 64'h34);
        cnt_we_i = 1'b1; cnth_we_i = 1'b1; wr_idx_i = 3'd3; wr_val_i = 32'hB;
        tick();
        cnt_we_i = 1'b0; cnth_we_i = 1'b0;
        read_chk("wr.both", 3, 1'b0, 64'h0000_000B_0000_1234, 64'h34);

        // Select beyond NumEvents never counts
        cfg(4, 13, 1'b1, 1'b0);
        wr_lo(4, 32'd7);
        pulse(12'hFFF, 3);
        read_chk("sel.oor", 4, 1'b0, 64'd7, 64'd7);
        tick();
        chk("hold.vld", 64'(rd_valid_a), 64'd0);
        chk("hold.w48", rd_data_a, 64'd7);
        chk("hold.w8",  rd_data_b, 64'd7);

        // Out-of-range indices
        wr_lo(6, 32'h55);
        read_chk("oor.rd6", 6, 1'b0, 64'd0, 64'd0);
        read_chk("oor.rd7", 7, 1'b1, 64'd0, 64'd0);
        read_chk("oor.ch4", 4, 1'b0, 64'd7, 64'd7);

        // Reset in the middle of activity
        cfg(1, 2, 1'b1, 1'b1);
        wr_lo(1, 32'hFF);
        pulse(12'h004, 1);
        chk("prerst.ovf", 64'(ovf_b), 64'h2);
        chk("prerst.irq", 64'(irq_b), 64'd1);
        events_i = 12'hFFF; snap_i = 1'b1; cnt_we_i = 1'b1; wr_idx_i = 3'd0;
        wr_val_i = 32'd99; rd_req_i = 1'b1; rd_idx_i = 3'd0; rd_shadow_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        events_i = '0; snap_i = 1'b0; cnt_we_i = 1'b0; rd_req_i = 1'b0;
        chk("midrst.vld",  64'(rd_valid_a | rd_valid_b), 64'd0);
        chk("midrst.data", rd_data_a | rd_data_b, 64'd0);
        chk("midrst.ovf",  64'(ovf_a | ovf_b), 64'd0);
        chk("midrst.irq",  64'(irq_a | irq_b), 64'd0);
        for (int i = 0; i < 6; i++) begin
            read_chk($sformatf("midrst.live%0d", i), i, 1'b0, 64'd0, 64'd0);
        end
        read_chk("midrst.sh2", 2, 1'b1, 64'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apmu_event_counter_bank.md
APMU_EVENT_COUNTER_BANK -- requirements
Module: apmu_event_counter_bank

Interface
REQ-001 SHALL have parameter NumCounters, default 8, number of counter channels (1..16).
REQ-002 SHALL have parameter CounterWidth, default 48, implemented bits per channel (1..64).
REQ-003 SHALL have parameter NumEvents, default 16, width of event input vector (1..32).
REQ-004 SHALL have ports, one per line:
 clk_i  in  1  sole clock
 rst_ni  in  1  reset; synchronous, active-low
 events_i  in  NumEvents  per-cycle event pulses
 cfg_we_i  in  1  write event select/enable of channel wr_idx_i
 cfg_sel_i  in  $clog2(NumEvents)  event index for channel
 cfg_en_i  in  1  channel count enable
 cfg_ie_i  in  1  channel overflow interrupt enable
 wr_idx_i  in  $clog2(NumCounters)  channel addressed by writes
 cnt_we_i  in  1  write low 32 bits of channel
 cnth_we_i  in  1  write high 32 bits of channel
 wr_val_i  in  32  write data
 ovf_clr_i  in  NumCounters  write-one-to-clear overflow flags
 snap_i  in  1  copy all live counters into shadow bank
 rd_req_i  in  1  read request
 rd_idx_i  in  $clog2(NumCounters)  channel to read
 rd_shadow_i  in  1  read shadow (1) or live (0) value
 rd_valid_o  out  1  read data valid
 rd_data_o  out  64  read data, zero-extended
 ovf_o  out  NumCounters  sticky overflow flags
 irq_o  out  1  OR over channels of ovf & ie

Function
REQ-005 Channel increments by 1 in cycle N when en=1 and events_i[sel]=1 in cycle N; new value visible on live read issued in cycle N+1.
REQ-006 Increment arithmetic modulo 2^CounterWidth; all-ones + 1 wraps to 0 and sets that channel's ovf flag at the same edge.
REQ-007 cnt_we_i loads wr_val_i into bits [31:0], high bits kept; cnth_we_i loads wr_val_i into bits [63:32], low bits kept; bits at or above CounterWidth discarded.
REQ-008 cnt_we_i and cnth_we_i both high: cnth_we_i wins (only high half written).
REQ-009 Write to a channel in the same cycle as its increment: write wins, increment lost, no overflow set.
REQ-010 cfg_sel_i >= NumEvents: channel never counts; stored value retained.
REQ-011 cfg_we_i takes effect for events from the next cycle; does not alter count value or ovf.
REQ-012 ovf set and ovf_clr_i on the same channel in one cycle: set wins.
REQ-013 irq_o combinational from registered ovf and ie; no latency beyond flag update.
REQ-014 snap_i copies every channel's pre-edge live value (excluding same-cycle increment/write) into the shadow bank in one cycle.
REQ-015 Read: rd_req_i in cycle N gives rd_valid_o=1 and rd_data_o in cycle N+1 exactly one cycle; rd_data_o holds last value when rd_valid_o=0.
REQ-016 Live read returns pre-edge value of cycle N; shadow read in the same cycle as snap_i returns old shadow.
REQ-017 rd_idx_i or wr_idx_i >= NumCounters: reads return 0 with rd_valid_o=1; writes ignored.
REQ-018 Bits [63:CounterWidth] of rd_data_o SHALL read 0.

Reset
REQ-019 rst_ni low at a clock edge clears all counters, shadows, sel, en, ie, ovf_o, rd_valid_o, rd_data_o to 0; irq_o thus 0.
REQ-020 Reset mid-operation discards pending read and any same-cycle write, increment or snapshot.

Structure
REQ-021 Package apmu_cnt_pkg SHALL hold channel config struct (sel, en, ie) and parameter-range limit constants.
REQ-022 Per-channel logic (counter, shadow, ovf, next-value priority) SHALL be one sub-module apmu_counter_channel, instantiated NumCounters times.
REQ-023 Parameters outside stated ranges SHALL fail elaboration.

Verification
REQ-024 Ch0 sel=3 en=1, pulse events_i[3] 5 cycles -> live read ch0 = 5, other channels 0.
REQ-025 CounterWidth=8, write ch1 = 0xFF, one event -> ch1 = 0, ovf_o[1]=1, irq_o=1 iff ie=1; ovf_clr_i[1] -> ovf_o[1]=0.
REQ-026 ch2 = 0x10, snap_i with event same cycle -> shadow 0x10, live 0x11.
REQ-027 cnt_we_i value 0x1234 with coincident event -> ch reads 0x1234; cnth_we_i 0xA on CounterWidth=48 -> reads 0x0000_000A_0000_1234.
REQ-028 rd_idx_i = NumCounters -> rd_valid_o=1, rd_data_o=0 next cycle.
REQ-029 rst_ni low one cycle during counting -> all reads 0, ovf_o=0, irq_o=0.
